// File: rtl/core_pkg.sv
// Shared encodings for the unified memory port arbiter.
package core_pkg;

    // Port state: free, or one read outstanding
    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_t;

    // Which requester owns the outstanding read
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/arb_latency_timer.sv
// Read latency down-counter: loaded on a read grant, reads zero in the
// cycle the memory returns data.
module arb_latency_timer #(
    parameter int MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic cnt_zero
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

    logic [CNT_W-1:0] cnt;

    // Load on grant, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port BRAM between instruction fetch and the
// MEM stage. Data wins by default; fetch wins when data is idle or after
// STARVE_LIMIT consecutive denied fetch cycles. Optional stall counters are
// built when MEM_ARB_PERF_CNT_EN is defined.
//
// state       | meaning
// ARB_IDLE    | port free, any request may be granted
// ARB_RD_WAIT | read outstanding for 'owner'; regrant allowed on expiry
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]       ifStallCnt,
    output logic [31:0]       memStallCnt,
`endif
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic              iGnt,
    output logic              iRvalid,
    output logic [31:0]       iRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [3:0]        dBe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [31:0]       dWdata,
    output logic              dGnt,
    output logic              dRvalid,
    output logic [31:0]       dRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [3:0]        memBe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    input  logic [31:0]       memRdata,
    output logic              ifStall,
    output logic              memStall
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state;
    arb_owner_t          owner;
    logic [STARVE_W-1:0] starve_cnt;
    logic                timer_zero;
    logic                expire;
    logic                eligible;
    logic                i_win;
    logic                d_win;
    logic                d_write;
    logic                rd_grant;

    arb_latency_timer #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .load    (rd_grant),
        .cnt_zero(timer_zero)
    );

    // Outputs are gated by resetn so a reset cycle shows a quiet port even
    // while the state register still holds a stale read.
    assign expire   = resetn && (state == ARB_RD_WAIT) && timer_zero;
    assign eligible = resetn && ((state == ARB_IDLE) || timer_zero);

    // Grant decision: data by default, fetch when data is idle or starving
    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (eligible) begin
            i_win = iReq && (!dReq || (starve_cnt >= STARVE_MAX));
            d_win = dReq && !i_win;
        end
    end

    assign d_write  = d_win && dWe;
    assign rd_grant = i_win || (d_win && !dWe);

    // Memory port drive from the winner; fetches and loads read all bytes
    always_comb begin
        memEn    = i_win || d_win;
        memWe    = d_write;
        memBe    = 4'h0;
        memAddr  = '0;
        memWdata = '0;
        if (i_win) begin
            memBe   = BE_ALL;
            memAddr = iAddr;
        end else if (d_win) begin
            memBe    = dWe ? dBe : BE_ALL;
            memAddr  = dAddr;
            memWdata = dWe ? dWdata : 32'h0;
        end
    end

    assign iGnt    = i_win;
    assign dGnt    = d_win;
    assign iRvalid = expire && (owner == OWN_IF);
    assign dRvalid = expire && (owner == OWN_MEM);
    assign iRdata  = iRvalid ? memRdata : 32'h0;
    assign dRdata  = dRvalid ? memRdata : 32'h0;

    assign ifStall  = iReq && !iRvalid;
    assign memStall = dReq && (dWe ? !dGnt : !dRvalid);

    // Port FSM: enter RD_WAIT on a read grant, drop to IDLE when eligible
    // and no read was granted, otherwise hold the outstanding read
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ARB_IDLE;
            owner <= OWN_IF;
        end else if (rd_grant) begin
            state <= ARB_RD_WAIT;
            owner <= i_win ? OWN_IF : OWN_MEM;
        end else if (eligible) begin
            state <= ARB_IDLE;
        end
    end

    // Count consecutive eligible cycles where a waiting fetch lost to data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!iReq || i_win) begin
            starve_cnt <= '0;
        end else if (d_win && (starve_cnt < STARVE_MAX)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] if_stall_q;
    logic [31:0] mem_stall_q;

    // Free-running stall cycle counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (!resetn) begin
            if_stall_q  <= '0;
            mem_stall_q <= '0;
        end else begin
            if_stall_q  <= if_stall_q + 32'(ifStall);
            mem_stall_q <= mem_stall_q + 32'(memStall);
        end
    end

    assign ifStallCnt  = resetn ? if_stall_q : 32'h0;
    assign memStallCnt = resetn ? mem_stall_q : 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a BRAM model and a
// cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int LAT = 3;
    localparam int SL  = 4;
    localparam int AW  = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          iReq, iGnt, iRvalid;
    logic [AW-1:0] iAddr;
    logic [31:0]   iRdata;
    logic          dReq, dWe, dGnt, dRvalid;
    logic [3:0]    dBe;
    logic [AW-1:0] dAddr;
    logic [31:0]   dWdata, dRdata;
    logic          memEn, memWe;
    logic [3:0]    memBe;
    logic [AW-1:0] memAddr;
    logic [31:0]   memWdata, memRdata;
    logic          ifStall, memStall;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]   ifStallCnt, memStallCnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SL), .ADDR_W(AW)) dut (
`ifdef MEM_ARB_PERF_CNT_EN
        .ifStallCnt(ifStallCnt), .memStallCnt(memStallCnt),
`endif
        .clk(clk), .resetn(resetn),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRvalid(iRvalid), .iRdata(iRdata),
        .dReq(dReq), .dWe(dWe), .dBe(dBe), .dAddr(dAddr), .dWdata(dWdata),
        .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata),
        .memEn(memEn), .memWe(memWe), .memBe(memBe), .memAddr(memAddr),
        .memWdata(memWdata), .memRdata(memRdata),
        .ifStall(ifStall), .memStall(memStall)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'hC3A51E0F;
    endfunction

    // BRAM model: byte-enabled writes, reads appear LAT cycles after memEn
    logic [31:0] mem_env [256];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 256; i++) mem_env[i] <= init_word(i);
        end else if (memEn && memWe) begin
            for (int b = 0; b < 4; b++)
                if (memBe[b]) mem_env[memAddr[9:2]][8*b +: 8] <= memWdata[8*b +: 8];
        end
        rd_pipe[0] <= (memEn && !memWe) ? mem_env[memAddr[9:2]] : 32'h0BAD0BAD;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign memRdata = rd_pipe[LAT-1];

    int total = 0;
    int bad   = 0;

    // Reference model: pending read as (owner, due cycle, data), shadow memory
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_owner = 0;
    int          m_due = 0;
    logic [31:0] m_data = '0;
    int          m_starve = 0;
    int unsigned m_ifcnt = 0, m_memcnt = 0;
    logic [31:0] shadow [256];
    bit          due_now, elig;
    logic        e_ignt, e_dgnt, e_irv, e_drv, e_memen, e_memwe, e_ifstall, e_memstall;
    logic [3:0]  e_membe;
    logic [AW-1:0] e_memaddr;

    task automatic model_eval();
        #1;
        due_now = m_busy && (cyc == m_due);
        elig    = !m_busy || due_now;
        e_ignt = 0; e_dgnt = 0; e_irv = 0; e_drv = 0; e_memen = 0; e_memwe = 0;
        e_membe = 4'hF; e_memaddr = '0;
        if (resetn) begin
            e_irv     = due_now && !m_owner;
            e_drv     = due_now && m_owner;
            e_ignt    = elig && iReq && (!dReq || m_starve >= SL);
            e_dgnt    = elig && dReq && !e_ignt;
            e_memen   = e_ignt || e_dgnt;
            e_memwe   = e_dgnt && dWe;
            e_membe   = e_memwe ? dBe : 4'hF;
            e_memaddr = e_ignt ? iAddr : dAddr;
        end
        e_ifstall  = iReq && !e_irv;
        e_memstall = dReq && (dWe ? !e_dgnt : !e_drv);
    endtask

    task automatic tick();
        if (!resetn) begin
            m_busy = 0; m_starve = 0; m_ifcnt = 0; m_memcnt = 0;
            for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        end else begin
            m_ifcnt  += 32'(e_ifstall);
            m_memcnt += 32'(e_memstall);
            if (due_now) m_busy = 0;
            if (e_ignt || (e_dgnt && !dWe)) begin
                m_busy = 1; m_owner = e_dgnt; m_due = cyc + LAT;
                m_data = shadow[e_memaddr[9:2]];
            end
            if (e_memwe)
                for (int b = 0; b < 4; b++)
                    if (dBe[b]) shadow[dAddr[9:2]][8*b +: 8] = dWdata[8*b +: 8];
            if (!iReq || e_ignt) m_starve = 0;
            else if (e_dgnt && m_starve < SL) m_starve++;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = '0;
        a[9:2] = 8'($urandom_range(0, 255));
        return a;
    endfunction

    task automatic test_reset();
        resetn = 0; iReq = 0; iAddr = '0; dReq = 0; dWe = 0; dBe = '0; dAddr = '0; dWdata = '0;
        for (int c = 0; c < 2; c++) begin
            model_eval();
            total++; if ({iGnt, dGnt, memEn, memWe, iRvalid, dRvalid, ifStall, memStall} !== 8'h00) begin bad++; $display("FAIL reset_flags got=%b want=00000000", {iGnt, dGnt, memEn, memWe, iRvalid, dRvalid, ifStall, memStall}); end
            total++; if (memAddr !== '0 || memBe !== 4'h0) begin bad++; $display("FAIL reset_bus addr=%h be=%h want 0", memAddr, memBe); end
            tick();
        end
        resetn = 1;
        model_eval();
        total++; if (memEn !== 1'b0 || iGnt !== 1'b0) begin bad++; $display("FAIL reset_idle memEn=%b iGnt=%b want 0", memEn, iGnt); end
`ifdef MEM_ARB_PERF_CNT_EN
        total++; if (ifStallCnt !== 32'd0 || memStallCnt !== 32'd0) begin bad++; $display("FAIL reset_perf if=%0d mem=%0d want 0", ifStallCnt, memStallCnt); end
`endif
        tick();
    endtask

    task automatic test_single_fetch();
        iReq = 1; iAddr = 32'h100;
        model_eval();
        total++; if (iGnt !== 1'b1 || memEn !== 1'b1) begin bad++; $display("FAIL fetch_gnt iGnt=%b memEn=%b want 1", iGnt, memEn); end
        total++; if (memAddr !== 32'h100 || memWe !== 1'b0 || memBe !== 4'hF) begin bad++; $display("FAIL fetch_bus addr=%h we=%b be=%h want 100/0/f", memAddr, memWe, memBe); end
        total++; if (ifStall !== 1'b1) begin bad++; $display("FAIL fetch_stall0 got=%b want 1", ifStall); end
        tick();
        for (int k = 1; k < LAT; k++) begin
            model_eval();
            total++; if (memEn !== 1'b0 || iRvalid !== 1'b0 || ifStall !== 1'b1) begin bad++; $display("FAIL fetch_wait k=%0d memEn=%b rv=%b stall=%b want 0/0/1", k, memEn, iRvalid, ifStall); end
            tick();
        end
        iReq = 0;
        model_eval();
        total++; if (iRvalid !== 1'b1) begin bad++; $display("FAIL fetch_rvalid got=%b want 1", iRvalid); end
        total++; if (iRdata !== init_word(32'h100 >> 2) || iRdata !== m_data) begin bad++; $display("FAIL fetch_rdata got=%h want %h", iRdata, init_word(32'h100 >> 2)); end
        tick();
`ifdef MEM_ARB_PERF_CNT_EN
        model_eval();
        total++; if (ifStallCnt !== 32'(LAT) || memStallCnt !== 32'd0) begin bad++; $display("FAIL perf_fetch if=%0d mem=%0d want %0d/0", ifStallCnt, memStallCnt, LAT); end
        tick();
`endif
    endtask

    task automatic test_contention();
        iReq = 1; iAddr = 32'h40;
        dReq = 1; dWe = 1; dAddr = 32'h200; dBe = 4'b0011; dWdata = 32'hDEADBEEF;
        model_eval();
        total++; if (dGnt !== 1'b1 || iGnt !== 1'b0) begin bad++; $display("FAIL cont_gnt dGnt=%b iGnt=%b want 1/0", dGnt, iGnt); end
        total++; if (memWe !== 1'b1 || memBe !== 4'b0011 || memAddr !== 32'h200 || memWdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cont_bus we=%b be=%b addr=%h wd=%h", memWe, memBe, memAddr, memWdata); end
        total++; if (ifStall !== 1'b1 || memStall !== 1'b0) begin bad++; $display("FAIL cont_stall if=%b mem=%b want 1/0", ifStall, memStall); end
        tick();
        dReq = 0; dWe = 0;
        model_eval();
        total++; if (iGnt !== 1'b1 || memAddr !== 32'h40) begin bad++; $display("FAIL cont_fetch iGnt=%b addr=%h want 1/40", iGnt, memAddr); end
        tick();
        for (int k = 1; k < LAT; k++) begin model_eval(); tick(); end
        iReq = 0;
        model_eval();
        total++; if (iRvalid !== 1'b1 || iRdata !== m_data) begin bad++; $display("FAIL cont_rvalid rv=%b data=%h want 1/%h", iRvalid, iRdata, m_data); end
        tick();
    endtask

    task automatic test_starvation();
        int seq[$];
        int want[6] = '{1, 1, 1, 1, 0, 1};
        iReq = 1; iAddr = 32'h80; dReq = 1; dWe = 1; dBe = 4'hF;
        for (int c = 0; c < 4 + LAT + 4 && seq.size() < 6; c++) begin
            dAddr = 32'h300 + 32'(4 * c); dWdata = $urandom;
            if (m_busy && cyc == m_due && !m_owner) iReq = 0;
            model_eval();
            total++; if (dGnt !== e_dgnt || iGnt !== e_ignt) begin bad++; $display("FAIL starve_step c=%0d dGnt=%b iGnt=%b want %b/%b", c, dGnt, iGnt, e_dgnt, e_ignt); end
            if (dGnt === 1'b1) seq.push_back(1);
            if (iGnt === 1'b1) seq.push_back(0);
            tick();
        end
        dReq = 0; dWe = 0; iReq = 0;
        total++;
        if (seq.size() != 6) begin
            bad++; $display("FAIL starve_count got=%0d grants want 6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++)
                if (seq[i] != want[i]) begin bad++; $display("FAIL starve_order idx=%0d got=%0d want=%0d", i, seq[i], want[i]); break; end
        end
    endtask

    task automatic test_back_to_back();
        dReq = 1; dWe = 0; dBe = 4'h0; dAddr = 32'h200;
        model_eval();
        total++; if (dGnt !== 1'b1 || memWe !== 1'b0 || memBe !== 4'hF || memStall !== 1'b1) begin bad++; $display("FAIL b2b_gnt0 gnt=%b we=%b be=%h stall=%b", dGnt, memWe, memBe, memStall); end
        tick();
        for (int k = 1; k < LAT; k++) begin
            model_eval();
            total++; if (memEn !== 1'b0 || dRvalid !== 1'b0) begin bad++; $display("FAIL b2b_wait0 k=%0d memEn=%b rv=%b want 0/0", k, memEn, dRvalid); end
            tick();
        end
        dAddr = 32'h204;
        model_eval();
        total++; if (dRvalid !== 1'b1 || dGnt !== 1'b1 || memAddr !== 32'h204) begin bad++; $display("FAIL b2b_regrant rv=%b gnt=%b addr=%h want 1/1/204", dRvalid, dGnt, memAddr); end
        total++; if (dRdata[15:0] !== 16'hBEEF || dRdata !== m_data) begin bad++; $display("FAIL b2b_data0 got=%h want %h", dRdata, m_data); end
        total++; if (memStall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b want 0", memStall); end
        tick();
        for (int k = 1; k < LAT; k++) begin
            model_eval();
            total++; if (dRvalid !== 1'b0) begin bad++; $display("FAIL b2b_wait1 k=%0d rv=%b want 0", k, dRvalid); end
            tick();
        end
        dReq = 0;
        model_eval();
        total++; if (dRvalid !== 1'b1 || dRdata !== m_data) begin bad++; $display("FAIL b2b_data1 rv=%b got=%h want 1/%h", dRvalid, dRdata, m_data); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        dReq = 1; dWe = 0; dAddr = 32'h10;
        model_eval();
        total++; if (dGnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b want 1", dGnt); end
        tick();
        resetn = 0; dReq = 0;
        model_eval();
        total++; if ({iGnt, dGnt, memEn, memWe, iRvalid, dRvalid, ifStall, memStall} !== 8'h00) begin bad++; $display("FAIL rmid_flags got=%b want 00000000", {iGnt, dGnt, memEn, memWe, iRvalid, dRvalid, ifStall, memStall}); end
        tick();
        resetn = 1;
        for (int k = 0; k <= LAT; k++) begin
            model_eval();
            total++; if (dRvalid !== 1'b0 || iRvalid !== 1'b0) begin bad++; $display("FAIL rmid_norv k=%0d d=%b i=%b want 0", k, dRvalid, iRvalid); end
            tick();
        end
        iReq = 1; iAddr = 32'h20;
        model_eval();
        total++; if (iGnt !== 1'b1) begin bad++; $display("FAIL rmid_idle_gnt got=%b want 1", iGnt); end
        tick();
        for (int k = 1; k < LAT; k++) begin model_eval(); tick(); end
        iReq = 0;
        model_eval();
        total++; if (iRvalid !== 1'b1 || iRdata !== init_word(32'h20 >> 2)) begin bad++; $display("FAIL rmid_fetch rv=%b got=%h want 1/%h", iRvalid, iRdata, init_word(32'h20 >> 2)); end
        tick();
    endtask

    task automatic test_random(int n);
        bit i_act, d_act, pd;
        i_act = 0; d_act = 0;
        for (int c = 0; c < n + 4 * LAT; c++) begin
            if (c >= n && !i_act && !d_act) break;
            pd = m_busy && (cyc == m_due);
            if (i_act && pd && !m_owner) i_act = 0;
            if (d_act && !dWe && pd && m_owner) d_act = 0;
            if (c < n && !i_act && $urandom_range(0, 2) != 0) begin i_act = 1; iAddr = rand_addr(); end
            if (c < n && !d_act && $urandom_range(0, 1) == 1) begin
                d_act = 1; dWe = 1'($urandom_range(0, 1)); dBe = 4'($urandom_range(0, 15));
                dAddr = rand_addr(); dWdata = $urandom;
            end
            iReq = i_act; dReq = d_act;
            model_eval();
            total++; if (iGnt !== e_ignt || dGnt !== e_dgnt || memEn !== e_memen || memWe !== e_memwe) begin bad++; $display("FAIL rnd_gnt cyc=%0d i/d/en/we=%b%b%b%b want %b%b%b%b", cyc, iGnt, dGnt, memEn, memWe, e_ignt, e_dgnt, e_memen, e_memwe); end
            total++; if (iRvalid !== e_irv || dRvalid !== e_drv) begin bad++; $display("FAIL rnd_rvalid cyc=%0d i=%b d=%b want %b/%b", cyc, iRvalid, dRvalid, e_irv, e_drv); end
            total++; if (ifStall !== e_ifstall || memStall !== e_memstall) begin bad++; $display("FAIL rnd_stall cyc=%0d if=%b mem=%b want %b/%b", cyc, ifStall, memStall, e_ifstall, e_memstall); end
            if (e_memen) begin
                total++; if (memAddr !== e_memaddr || memBe !== e_membe) begin bad++; $display("FAIL rnd_bus cyc=%0d addr=%h be=%h want %h/%h", cyc, memAddr, memBe, e_memaddr, e_membe); end
            end
            if (e_memwe) begin
                total++; if (memWdata !== dWdata) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h want %h", cyc, memWdata, dWdata); end
            end
            if (e_irv) begin
                total++; if (iRdata !== m_data) begin bad++; $display("FAIL rnd_irdata cyc=%0d got=%h want %h", cyc, iRdata, m_data); end
            end
            if (e_drv) begin
                total++; if (dRdata !== m_data) begin bad++; $display("FAIL rnd_drdata cyc=%0d got=%h want %h", cyc, dRdata, m_data); end
            end
`ifdef MEM_ARB_PERF_CNT_EN
            total++; if (ifStallCnt !== m_ifcnt || memStallCnt !== m_memcnt) begin bad++; $display("FAIL rnd_perf cyc=%0d if=%0d mem=%0d want %0d/%0d", cyc, ifStallCnt, memStallCnt, m_ifcnt, m_memcnt); end
`endif
            if (e_dgnt && dWe) d_act = 0;
            tick();
        end
        total++; if (i_act || d_act) begin bad++; $display("FAIL rnd_drain_timeout i=%b d=%b want idle", i_act, d_act); end
        iReq = 0; dReq = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();
        test_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
